inst_assembler: RTL and testbench
=================================

INST_ASSEMBLER -- requirements
Module: inst_assembler

Interface
REQ-001 Parameter BASE_ADDR, default 32'hBFC0_0000: word address loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries; shall be a power of two, at least 2.
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 resetn  input  1: reset, asynchronous, active-low.
REQ-005 byte_in  input  8: instruction byte from the ROM stream.
REQ-006 byte_valid  input  1: byte_in holds a valid byte this cycle.
REQ-007 byte_ready  output  1: block accepts byte_in this cycle.
REQ-008 flush  input  1: synchronous discard of partial word and FIFO, then address reload.
REQ-009 flush_addr  input  32: new word address on flush; bits [1:0] ignored.
REQ-010 inst  output  32: instruction word at FIFO head.
REQ-011 inst_addr  output  32: byte address of inst, always 4-aligned.
REQ-012 inst_valid  output  1: FIFO non-empty.
REQ-013 inst_ready  input  1: consumer takes head this cycle.

Function
REQ-014 A byte shall be accepted on a rising edge where byte_valid && byte_ready && !flush.
REQ-015 A 2-bit byte_cnt shall count accepted bytes 0..3 and wrap 3->0 on the 4th accept.
REQ-016 Packing shall be big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-017 On the 4th accept, the completed word and the current addr counter shall be pushed into the FIFO on that same edge; the addr counter shall advance by 4, wrapping modulo 2^32.
REQ-018 Latency: inst_valid shall rise in the cycle immediately after the edge that accepts the 4th byte, when the FIFO was empty.
REQ-019 byte_ready shall be (byte_cnt != 3) || !fifo_full, driven from registered state only; no combinational path from inst_ready.
REQ-020 A pop shall occur on a rising edge where inst_valid && inst_ready && !flush; FIFO is show-ahead, so inst/inst_addr reflect the new head in the following cycle.
REQ-021 Simultaneous push and pop shall leave the occupancy unchanged and keep FIFO order.
REQ-022 While inst_valid is 0, inst and inst_addr shall be driven to 0.
REQ-023 flush shall take priority over push and pop: byte_cnt <= 0, partial word discarded, FIFO emptied, addr <= {flush_addr[31:2], 2'b00}; byte_valid and inst_ready are ignored that cycle.
REQ-024 The first word completed after a flush shall carry inst_addr = {flush_addr[31:2], 2'b00}.
REQ-025 Occupancy shall never exceed FIFO_DEPTH or underflow; a pop while empty is impossible because inst_valid = 0.

Reset
REQ-026 resetn low shall immediately force byte_cnt = 0, FIFO empty, addr = BASE_ADDR, and the partial word to 0.
REQ-027 During reset, the outputs shall be inst_valid = 0, inst = 0, inst_addr = 0, and byte_ready = 1.
REQ-028 Reset asserted mid-word or mid-transfer shall discard all buffered data; the first word after release starts at BASE_ADDR.

Structure
REQ-029 The BASE_ADDR default, the FIFO_DEPTH default, and the instruction-word width constant (32) shall live in the shared MIPS package.
REQ-030 The FIFO shall be one sub-module, sync_fifo, parameterized by width (64 bits: address plus data) and depth, with push/pop/flush/full/empty.
REQ-031 Byte packing, byte_cnt and the address counter shall reside in inst_assembler itself.

Verification
REQ-032 Stream from reset: 8'h24, 08, 00, 05 with inst_ready = 1 -> inst = 32'h2408_0005, inst_addr = 32'hBFC0_0000, inst_valid high one cycle after the 4th byte.
REQ-033 Backpressure: inst_ready = 0, 20 continuous bytes -> 4 words buffered; byte_ready = 0 with byte_cnt = 3; no byte lost; drained words arrive in order at addresses BFC0_0000..BFC0_000C.
REQ-034 Simultaneous push/pop with FIFO holding 2 words -> occupancy stays 2; the output order matches the input order.
REQ-035 flush with flush_addr = 32'h0000_1003 after 2 bytes of a word -> partial word discarded, FIFO empty; next word has inst_addr = 32'h0000_1000.
REQ-036 resetn pulsed low mid-word with 3 words queued -> inst_valid = 0 immediately; after release, the next word has inst_addr = BFC0_0000.
REQ-037 Address wrap: flush_addr = 32'hFFFF_FFFC, then 8 bytes -> the two words have inst_addr FFFF_FFFC, then 0000_0000.

Source files
------------

// File: rtl/inst_assembler_pkg.sv
// Shared MIPS front-end constants and the instruction FIFO entry type.
package inst_assembler_pkg;

  localparam int unsigned INST_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 32'hBFC0_0000;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } inst_entry_t;

  localparam int unsigned ENTRY_W = $bits(inst_entry_t);

  // Instruction words are always 4-byte aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/inst_assembler_if.sv
// Byte-stream input and instruction-word output of the assembler.
interface inst_assembler_if;
  import inst_assembler_pkg::*;

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output byte_in, byte_valid, flush, flush_addr, inst_ready,
    input  byte_ready, inst, inst_addr, inst_valid
  );

  modport slave (
    input  byte_in, byte_valid, flush, flush_addr, inst_ready,
    output byte_ready, inst, inst_addr, inst_valid
  );
endinterface

// File: rtl/inst_assembler_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inst_assembler.sv
// Packs a big-endian ROM byte stream into addressed 32-bit instruction words.
module inst_assembler
  import inst_assembler_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned       FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic              clk,
  input logic              resetn,
  inst_assembler_if.slave  bus
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [1:0]        byte_cnt;
  logic [23:0]       partial;
  logic [ADDR_W-1:0] addr;
  logic              byte_ready;
  logic              accept;
  logic              last_byte;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  inst_entry_t       push_entry;
  inst_entry_t       head;

  // Stall only when the word about to complete has nowhere to go.
  assign last_byte  = (byte_cnt == 2'd3);
  assign byte_ready = !last_byte || !fifo_full;
  assign accept     = bus.byte_valid && byte_ready && !bus.flush;
  assign push       = accept && last_byte;
  assign pop        = !fifo_empty && bus.inst_ready && !bus.flush;

  assign push_entry.addr = addr;
  assign push_entry.data = {partial, bus.byte_in};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_cnt <= '0;
      partial  <= '0;
      addr     <= BASE_ADDR;
    end else if (bus.flush) begin
      byte_cnt <= '0;
      partial  <= '0;
      addr     <= word_align(bus.flush_addr);
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      if (last_byte) begin
        partial <= '0;
        addr    <= addr + ADDR_W'(4);
      end else begin
        partial <= {partial[15:0], bus.byte_in};
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (push_entry),
    .pop    (pop),
    .flush  (bus.flush),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Head is masked to zero while the FIFO is empty.
  assign bus.byte_ready = byte_ready;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst       = fifo_empty ? '0 : head.data;
  assign bus.inst_addr  = fifo_empty ? '0 : head.addr;

endmodule

// File: tb/tb_inst_assembler.sv
// Scoreboard bench: byte-level reference model predicts words; monitor checks every cycle.
module tb_inst_assembler;

  localparam logic [31:0] TB_BASE  = 32'hBFC0_0000;
  localparam int          TB_DEPTH = 4;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  inst_assembler_if bus();

  inst_assembler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: bytes of the word in progress, queued words, next address.
  logic [7:0]  part_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    logic        exp_ready;
    if (!resetn) begin
      chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
      chk("rst_inst", 64'(bus.inst), 64'd0);
      chk("rst_inst_addr", 64'(bus.inst_addr), 64'd0);
      chk("rst_byte_ready", 64'(bus.byte_ready), 64'd1);
      part_q.delete();
      exp_q.delete();
      m_addr = TB_BASE;
    end else begin
      exp_ready = (part_q.size() != 3) || (exp_q.size() < TB_DEPTH);
      chk("byte_ready", 64'(bus.byte_ready), 64'(exp_ready));
      chk("inst_valid", 64'(bus.inst_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
        chk("idle_inst", 64'(bus.inst), 64'd0);
        chk("idle_inst_addr", 64'(bus.inst_addr), 64'd0);
      end
      if (bus.flush) begin
        part_q.delete();
        exp_q.delete();
        m_addr = {bus.flush_addr[31:2], 2'b00};
      end else begin
        if (bus.inst_valid && bus.inst_ready) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("inst_addr", 64'(bus.inst_addr), 64'(e[63:32]));
            chk("inst", 64'(bus.inst), 64'(e[31:0]));
          end
        end
        if (bus.byte_valid && bus.byte_ready) begin
          part_q.push_back(bus.byte_in);
          if (part_q.size() == 4) begin
            exp_q.push_back({m_addr, part_q[0], part_q[1], part_q[2], part_q[3]});
            m_addr = m_addr + 32'd4;
            part_q.delete();
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = bus.byte_ready && !bus.flush && resetn;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    if (!acc) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_flush(input logic [31:0] a);
    bus.flush      = 1'b1;
    bus.flush_addr = a;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic hi_ready;
    n_cmp = 0;
    n_bad = 0;
    resetn         = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.flush_addr = '0;
    bus.inst_ready = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);

    // First word from reset.
    bus.inst_ready = 1'b1;
    send_word(32'h2408_0005);
    idle(4);

    // Backpressure: 20 bytes with consumer stalled, then drain.
    bus.inst_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
      end
      begin
        repeat (30) @(posedge clk);
        #2;
        chk("bp_byte_ready", 64'(bus.byte_ready), 64'd0);
        chk("bp_inst_valid", 64'(bus.inst_valid), 64'd1);
        bus.inst_ready = 1'b1;
      end
    join
    idle(10);

    // Simultaneous push and pop with two words queued.
    bus.inst_ready = 1'b0;
    send_word(32'hA1A2_A3A4);
    send_word(32'hB1B2_B3B4);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    bus.inst_ready = 1'b1;
    send_byte(8'hC4);
    bus.inst_ready = 1'b0;
    idle(2);
    chk("pp_inst_valid", 64'(bus.inst_valid), 64'd1);
    bus.inst_ready = 1'b1;
    idle(6);

    // Flush after two bytes of a word.
    send_byte(8'hEE);
    send_byte(8'hDD);
    do_flush(32'h0000_1003);
    chk("flush_inst_valid", 64'(bus.inst_valid), 64'd0);
    send_word(32'h1122_3344);
    idle(4);

    // Reset mid-word with three words queued.
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 14; i++) send_byte(8'(8'h40 + i));
    chk("pre_rst_inst_valid", 64'(bus.inst_valid), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_imm_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_imm_ready", 64'(bus.byte_ready), 64'd1);
    idle(2);
    resetn = 1'b1;
    bus.inst_ready = 1'b1;
    send_word(32'h5566_7788);
    idle(4);

    // Address wrap.
    do_flush(32'hFFFF_FFFC);
    send_word(32'hCAFE_0001);
    send_word(32'hCAFE_0002);
    idle(4);

    // Randomized traffic with occasional flushes and bursty backpressure.
    hi_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) hi_ready = ~hi_ready;
      bus.byte_valid = ($urandom_range(0, 3) != 0);
      bus.byte_in    = 8'($urandom);
      bus.inst_ready = hi_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      bus.flush      = ($urandom_range(0, 59) == 0);
      bus.flush_addr = $urandom;
      idle(1);
    end
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.inst_ready = 1'b1;
    idle(12);
    chk("drain_all_seen", 64'(exp_q.size()), 64'd0);
    chk("drain_inst_valid", 64'(bus.inst_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
